rv_pbus_master: RTL and testbench

Initiator for the rv32 core's peripheral port into instruction/data RAM. It converts host-side burst commands into single-word peripheral-bus reads and writes, and retries every access until the RAM grants it. The RAM grants an access only when the CPU data bus is idle. The block sits between the host/debug/loader logic and the RAM's p_* port, and is used for program load, readback and mailbox traffic while the core runs.

---
 rtl/rv_pbus_master.sv | 195 +++++++++++++++++++
 tb/tb_rv_pbus_master.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_pbus_master.sv
// rv_pbus_master: turns host burst commands into single-word reads and writes
// on the RAM peripheral port. Each denied access is retried until the RAM
// grants it with p_ack & rdy. All outputs come from registers.
module rv_pbus_master #(
    parameter int Nk = 32
) (
    input  logic        clk,
    input  logic        xreset,
    input  logic        rdy,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_adr,
    input  logic [15:0] cmd_len,
    input  logic        wd_valid,
    output logic        wd_ready,
    input  logic [31:0] wd_data,
    output logic        rd_valid,
    input  logic        rd_ready,
    output logic [31:0] rd_data,
    output logic [31:0] p_adr,
    output logic [31:0] p_dw,
    input  logic [31:0] p_dr,
    output logic        p_we,
    output logic        p_re,
    input  logic        p_ack,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int Nb = $clog2(Nk) + 10;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR_FETCH = 3'd1,
        WR_BUS   = 3'd2,
        RD_BUS   = 3'd3,
        RD_CAP   = 3'd4,
        RD_HOLD  = 3'd5
    } state_t;

    // True when the word address lies inside the RAM.
    function automatic logic in_range_f(input logic [31:0] a);
        return ((a >> Nb) == 32'd0);
    endfunction

    // Output flags for a state: {busy, wd_ready, p_we, p_re, rd_valid}.
    // bus_ok suppresses p_re for an out-of-range read, which never reaches the bus.
    function automatic logic [4:0] flags_f(input state_t s, input logic bus_ok);
        logic [4:0] f;
        case (s)
            IDLE:     f = 5'b00000;
            WR_FETCH: f = 5'b11000;
            WR_BUS:   f = 5'b10100;
            RD_BUS:   f = {1'b1, 1'b0, 1'b0, bus_ok, 1'b0};
            RD_CAP:   f = 5'b10000;
            RD_HOLD:  f = 5'b10001;
            default:  f = 5'b00000;
        endcase
        return f;
    endfunction

    state_t      state_r;
    logic [31:0] adr_r;
    logic [15:0] cnt_r;
    logic        err_r;
    logic        done_r;
    logic        cmd_ready_r;
    logic [31:0] p_dw_r;
    logic [31:0] rd_data_r;
    logic [4:0]  flags_r;

    logic [31:0] start_adr_s;
    logic [31:0] adv_adr_s;
    logic        adv_last_s;
    state_t      adv_state_s;
    logic        grant_s;
    logic        adv_go_s;

    assign start_adr_s = cmd_adr & 32'hFFFF_FFFC;
    assign adv_adr_s   = adr_r + 32'd4;
    assign adv_last_s  = (cnt_r == 16'd1);
    assign adv_state_s = (state_r == RD_HOLD) ? RD_BUS : WR_FETCH;
    assign grant_s     = p_ack & rdy;

    // Decide whether the current word is finished and the address moves on.
    always_comb begin
        adv_go_s = 1'b0;
        case (state_r)
            WR_FETCH: adv_go_s = wd_valid & ~in_range_f(adr_r);
            WR_BUS:   adv_go_s = grant_s;
            RD_HOLD:  adv_go_s = rd_ready;
            default:  adv_go_s = 1'b0;
        endcase
    end

    // Burst sequencer: state, address/count, data registers and registered outputs.
    always_ff @(posedge clk) begin
        if (!xreset) begin
            state_r     <= IDLE;
            adr_r       <= 32'd0;
            cnt_r       <= 16'd0;
            err_r       <= 1'b0;
            done_r      <= 1'b0;
            cmd_ready_r <= 1'b0;
            p_dw_r      <= 32'd0;
            rd_data_r   <= 32'd0;
            flags_r     <= 5'b00000;
        end else begin
            done_r <= 1'b0;
            if (adv_go_s) begin
                // A write fetch reaching here carries an out-of-range word: drop it.
                if (state_r == WR_FETCH) begin
                    p_dw_r <= wd_data;
                    err_r  <= 1'b1;
                end
                adr_r <= adv_adr_s;
                cnt_r <= cnt_r - 16'd1;
                if (adv_last_s) begin
                    state_r <= IDLE;
                    done_r  <= 1'b1;
                    flags_r <= flags_f(IDLE, 1'b0);
                end else begin
                    state_r <= adv_state_s;
                    flags_r <= flags_f(adv_state_s, in_range_f(adv_adr_s));
                end
            end else begin
                case (state_r)
                    IDLE: begin
                        if (cmd_valid && cmd_ready_r) begin
                            adr_r       <= start_adr_s;
                            cnt_r       <= cmd_len;
                            err_r       <= 1'b0;
                            cmd_ready_r <= 1'b0;
                            if (cmd_len == 16'd0) begin
                                done_r <= 1'b1;
                            end else if (cmd_write) begin
                                state_r <= WR_FETCH;
                                flags_r <= flags_f(WR_FETCH, 1'b1);
                            end else begin
                                state_r <= RD_BUS;
                                flags_r <= flags_f(RD_BUS, in_range_f(start_adr_s));
                            end
                        end else begin
                            // Also covers the done cycle: ready rises one cycle later.
                            cmd_ready_r <= 1'b1;
                        end
                    end
                    WR_FETCH: begin
                        if (wd_valid) begin
                            p_dw_r  <= wd_data;
                            state_r <= WR_BUS;
                            flags_r <= flags_f(WR_BUS, 1'b1);
                        end
                    end
                    RD_BUS: begin
                        if (!in_range_f(adr_r)) begin
                            err_r     <= 1'b1;
                            rd_data_r <= 32'd0;
                            state_r   <= RD_HOLD;
                            flags_r   <= flags_f(RD_HOLD, 1'b0);
                        end else if (grant_s) begin
                            state_r <= RD_CAP;
                            flags_r <= flags_f(RD_CAP, 1'b0);
                        end
                    end
                    RD_CAP: begin
                        rd_data_r <= p_dr;
                        state_r   <= RD_HOLD;
                        flags_r   <= flags_f(RD_HOLD, 1'b0);
                    end
                    WR_BUS, RD_HOLD: begin
                        // Waiting for a grant or for the consumer; nothing changes.
                        state_r <= state_r;
                    end
                    default: begin
                        state_r     <= IDLE;
                        cmd_ready_r <= 1'b0;
                        flags_r     <= flags_f(IDLE, 1'b0);
                    end
                endcase
            end
        end
    end

    assign {busy, wd_ready, p_we, p_re, rd_valid} = flags_r;
    assign cmd_ready = cmd_ready_r;
    assign p_adr     = adr_r;
    assign p_dw      = p_dw_r;
    assign rd_data   = rd_data_r;
    assign done      = done_r;
    assign err       = err_r;

endmodule

// File: tb/tb_rv_pbus_master.sv
// Directed bench for rv_pbus_master: bursts, contention, zero length,
// out-of-range addresses and mid-burst reset.
module tb_rv_pbus_master;

    logic        clk = 1'b0;
    logic        xreset, rdy, cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_adr;
    logic [15:0] cmd_len;
    logic        wd_valid, wd_ready, rd_valid, rd_ready;
    logic [31:0] wd_data, rd_data, p_adr, p_dw;
    logic [31:0] p_dr = 32'd0;
    logic        p_we, p_re, p_ack, busy, done, err;

    int tests = 0;
    int fails = 0;

    // Bus/stream monitors
    int          wr_n = 0, rd_n = 0, done_cnt = 0, both_cnt = 0;
    logic [31:0] wr_adr [0:15];
    logic [31:0] wr_dat [0:15];
    logic [31:0] rd_log [0:15];

    rv_pbus_master #(.Nk(32)) dut (
        .clk(clk), .xreset(xreset), .rdy(rdy),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_adr(cmd_adr), .cmd_len(cmd_len),
        .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .p_adr(p_adr), .p_dw(p_dw), .p_dr(p_dr), .p_we(p_we), .p_re(p_re),
        .p_ack(p_ack), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // RAM read-data model: returns adr ^ A5A5A5A5 one cycle after a granted read.
    always @(posedge clk) begin
        if (p_re && p_ack && rdy) p_dr <= p_adr ^ 32'hA5A5_A5A5;
    end

    // Record granted writes, read handshakes, done pulses and request overlap.
    always @(posedge clk) begin
        if (p_we && p_ack && rdy) begin
            wr_adr[wr_n & 15] <= p_adr;
            wr_dat[wr_n & 15] <= p_dw;
            wr_n <= wr_n + 1;
        end
        if (rd_valid && rd_ready) begin
            rd_log[rd_n & 15] <= rd_data;
            rd_n <= rd_n + 1;
        end
        if (done) done_cnt <= done_cnt + 1;
        if (p_we && p_re) both_cnt <= both_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic issue(input logic w, input logic [31:0] a, input logic [15:0] l);
        for (int i = 0; i < 10 && !cmd_ready; i++) step();
        chk("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_adr   = a;
        cmd_len   = l;
        step();
        cmd_valid = 1'b0;
    endtask

    initial begin
        int cyc, widx, stall, base_wr, base_rd, base_done;
        logic took;

        xreset = 1'b0; rdy = 1'b1; p_ack = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0;
        cmd_adr = 32'd0; cmd_len = 16'd0; wd_valid = 1'b0; wd_data = 32'd0; rd_ready = 1'b1;

        // Reset state
        step(); step(); step();
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        chk("rst_flags", {27'd0, busy, wd_ready, p_we, p_re, rd_valid}, 32'd0);
        chk("rst_done_err", {30'd0, done, err}, 32'd0);
        chk("rst_p_adr", p_adr, 32'd0);
        chk("rst_p_dw", p_dw, 32'd0);
        chk("rst_rd_data", rd_data, 32'd0);
        xreset = 1'b1;
        step();
        chk("post_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);

        // Uncontended 4-word write burst at 0x100
        base_wr = wr_n; base_done = done_cnt;
        wd_valid = 1'b1; wd_data = 32'h11; widx = 0;
        issue(1'b1, 32'h100, 16'd4);
        chk("wr_busy", {31'd0, busy}, 32'd1);
        cyc = 0;
        while (!done && cyc < 30) begin
            took = wd_ready && wd_valid;
            step(); cyc++;
            if (took) begin widx++; wd_data = 32'h11 * (widx + 1); end
        end
        wd_valid = 1'b0;
        chk("wr_latency", cyc, 32'd8);
        chk("wr_done_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        step();
        chk("wr_ready_after", {30'd0, cmd_ready, done}, 32'd2);
        chk("wr_count", wr_n - base_wr, 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("wr_adr", wr_adr[(base_wr + i) & 15], 32'h100 + 32'(4 * i));
            chk("wr_dat", wr_dat[(base_wr + i) & 15], 32'h11 * 32'(i + 1));
        end
        chk("wr_done_once", done_cnt - base_done, 32'd1);

        // Contended write: p_ack low 5 cycles on word 1, rdy low 3 cycles on word 2
        base_wr = wr_n;
        wd_valid = 1'b1; wd_data = 32'hAAAA_0001; p_ack = 1'b0;
        issue(1'b1, 32'h300, 16'd2);
        step();
        wd_data = 32'hAAAA_0002;
        for (int i = 0; i < 5; i++) begin
            chk("ack_hold_we", {31'd0, p_we}, 32'd1);
            chk("ack_hold_adr", p_adr, 32'h300);
            chk("ack_hold_dw", p_dw, 32'hAAAA_0001);
            step();
        end
        chk("ack_no_write", wr_n - base_wr, 32'd0);
        p_ack = 1'b1;
        step();
        rdy = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            chk("rdy_hold_we", {31'd0, p_we}, 32'd1);
            chk("rdy_hold_adr", p_adr, 32'h304);
            chk("rdy_hold_dw", p_dw, 32'hAAAA_0002);
            step();
        end
        rdy = 1'b1;
        step();
        wd_valid = 1'b0;
        chk("cont_done", {31'd0, done}, 32'd1);
        chk("cont_count", wr_n - base_wr, 32'd2);
        chk("cont_adr1", wr_adr[base_wr & 15], 32'h300);
        chk("cont_dat2", wr_dat[(base_wr + 1) & 15], 32'hAAAA_0002);

        // 3-word read at 0x200, consumer stalls 2 cycles on word 2
        base_rd = rd_n; base_done = done_cnt;
        issue(1'b0, 32'h200, 16'd3);
        cyc = 0; stall = 0;
        while (!done && cyc < 40) begin
            if (rd_valid && (rd_n - base_rd) == 1 && stall < 2) begin
                rd_ready = 1'b0; stall++;
            end else begin
                rd_ready = 1'b1;
            end
            step(); cyc++;
        end
        rd_ready = 1'b1;
        chk("rd_latency", cyc, 32'd11);
        chk("rd_count", rd_n - base_rd, 32'd3);
        chk("rd_word0", rd_log[base_rd & 15], 32'hA5A5_A7A5);
        chk("rd_word1", rd_log[(base_rd + 1) & 15], 32'hA5A5_A7A1);
        chk("rd_word2", rd_log[(base_rd + 2) & 15], 32'hA5A5_A7AD);

        // Zero length, then misaligned start address
        base_wr = wr_n;
        issue(1'b1, 32'h103, 16'd0);
        chk("len0_done", {31'd0, done}, 32'd1);
        chk("len0_idle", {27'd0, busy, wd_ready, p_we, p_re, rd_valid}, 32'd0);
        wd_valid = 1'b1; wd_data = 32'h55;
        issue(1'b1, 32'h103, 16'd1);
        step();
        chk("align_adr", p_adr, 32'h100);
        chk("align_we_dw", p_dw ^ {31'd0, p_we}, 32'h54);
        step();
        wd_valid = 1'b0;
        chk("align_done", {31'd0, done}, 32'd1);
        chk("align_count", wr_n - base_wr, 32'd1);

        // Out-of-range second word at 0x8000
        base_wr = wr_n;
        wd_valid = 1'b1; wd_data = 32'hCAFE_0001;
        issue(1'b1, 32'h7FFC, 16'd2);
        step();
        chk("oor_first_adr", p_adr, 32'h7FFC);
        wd_data = 32'hCAFE_0002;
        step();
        chk("oor_fetch", {30'd0, wd_ready, err}, 32'd2);
        step();
        wd_valid = 1'b0;
        chk("oor_err_done", {29'd0, err, done, p_we}, 32'd6);
        chk("oor_count", wr_n - base_wr, 32'd1);
        chk("oor_wr_adr", wr_adr[base_wr & 15], 32'h7FFC);
        step();
        chk("oor_sticky", {31'd0, err}, 32'd1);
        issue(1'b0, 32'h0, 16'd0);
        chk("err_cleared", {31'd0, err}, 32'd0);

        // Reset during word 2 of a 4-word read
        base_rd = rd_n;
        issue(1'b0, 32'h400, 16'd4);
        step(); step(); step();
        chk("rst_mid_words", rd_n - base_rd, 32'd1);
        step();
        xreset = 1'b0;
        step();
        chk("rst_mid_flags", {26'd0, cmd_ready, busy, wd_ready, p_we, p_re, rd_valid}, 32'd0);
        chk("rst_mid_done", {30'd0, done, err}, 32'd0);
        chk("rst_mid_adr", p_adr, 32'd0);
        chk("rst_mid_rd_data", rd_data, 32'd0);
        base_done = done_cnt;
        xreset = 1'b1;
        step();
        chk("rst_mid_ready", {31'd0, cmd_ready}, 32'd1);
        step(); step(); step();
        chk("rst_mid_no_done", done_cnt - base_done, 32'd0);
        issue(1'b0, 32'h10, 16'd1);
        cyc = 0;
        while (!done && cyc < 20) begin step(); cyc++; end
        chk("fresh_done", {31'd0, done}, 32'd1);
        chk("fresh_data", rd_log[(rd_n - 1) & 15], 32'hA5A5_A5B5);

        chk("never_both", both_cnt, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
